// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order retirement queue with registered commit/flush outputs
// Optional ROB_FWD_EN adds combinational operand lookup ports with same-cycle CDB bypass.
module reorder_buffer #(
    parameter int ROB_W  = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              Dispatch_alloc_S,
    input  logic [REG_W-1:0]  Dispatch_rd,
    input  logic [1:0]        Dispatch_type,
`ifdef ROB_FWD_EN
    input  logic [ROB_W-1:0]  Dispatch_q1_pos,
    input  logic [ROB_W-1:0]  Dispatch_q2_pos,
    output logic              ROB_q1_ready,
    output logic              ROB_q2_ready,
    output logic [DATA_W-1:0] ROB_q1_value,
    output logic [DATA_W-1:0] ROB_q2_value,
`endif
    output logic              ROB_full,
    output logic [ROB_W-1:0]  ROB_tail,
    input  logic              CDB_S,
    input  logic [ROB_W-1:0]  CDB_pos,
    input  logic [DATA_W-1:0] CDB_value,
    input  logic              CDB_mispred,
    input  logic [DATA_W-1:0] CDB_target,
    output logic              ROB_write_S,
    output logic [REG_W-1:0]  ROB_rd,
    output logic [ROB_W-1:0]  ROB_Reorder,
    output logic [DATA_W-1:0] ROB_result,
    output logic              ROB_store_S,
    input  logic              LSB_store_done,
    output logic              clr,
    output logic [DATA_W-1:0] clr_pc
);
    localparam int DEPTH = 1 << ROB_W;
    localparam logic [1:0] TYPE_BRANCH = 2'b01;
    localparam logic [1:0] TYPE_STORE  = 2'b10;

    typedef enum logic {IDLE, ST_WAIT} state_t;

    state_t             state_q, state_d;
    logic [ROB_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [ROB_W:0]     count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d, ready_q, ready_d, mispred_q, mispred_d;
    logic [1:0]         type_q   [DEPTH];
    logic [1:0]         type_d   [DEPTH];
    logic [REG_W-1:0]   rd_q     [DEPTH];
    logic [REG_W-1:0]   rd_d     [DEPTH];
    logic [DATA_W-1:0]  value_q  [DEPTH];
    logic [DATA_W-1:0]  value_d  [DEPTH];
    logic [DATA_W-1:0]  target_q [DEPTH];
    logic [DATA_W-1:0]  target_d [DEPTH];

    logic               write_s_q, write_s_d, store_s_q, store_s_d, clr_q, clr_d;
    logic [REG_W-1:0]   commit_rd_q, commit_rd_d;
    logic [ROB_W-1:0]   commit_pos_q, commit_pos_d;
    logic [DATA_W-1:0]  commit_val_q, commit_val_d, clr_pc_q, clr_pc_d;
    logic               full, do_alloc, do_cdb, retire;

    assign full        = (count_q == (ROB_W+1)'(DEPTH));
    assign ROB_full    = full;
    assign ROB_tail    = tail_q;
    assign ROB_rd      = commit_rd_q;
    assign ROB_Reorder = commit_pos_q;
    assign ROB_result  = commit_val_q;
    assign clr_pc      = clr_pc_q;
    // Pulses are held while rdy is low so a pending commit reappears once rdy returns.
    assign ROB_write_S = write_s_q & rdy;
    assign ROB_store_S = store_s_q & rdy;
    assign clr         = clr_q & rdy;

    always_comb begin
        state_d = state_q;   head_d = head_q;   tail_d = tail_q;   count_d = count_q;
        valid_d = valid_q;   ready_d = ready_q; mispred_d = mispred_q;
        type_d = type_q;     rd_d = rd_q;       value_d = value_q; target_d = target_q;
        write_s_d = write_s_q; store_s_d = store_s_q; clr_d = clr_q;
        commit_rd_d = commit_rd_q; commit_pos_d = commit_pos_q;
        commit_val_d = commit_val_q; clr_pc_d = clr_pc_q;
        do_alloc = 1'b0; do_cdb = 1'b0; retire = 1'b0;
        if (rdy) begin
            write_s_d = 1'b0; store_s_d = 1'b0; clr_d = 1'b0;
            if (clr_q) begin
                head_d = '0; tail_d = '0; count_d = '0;
                valid_d = '0; ready_d = '0; state_d = IDLE;
            end else begin
                do_alloc = Dispatch_alloc_S && !full;
                do_cdb   = CDB_S && valid_q[CDB_pos];
                if (do_alloc) begin
                    valid_d[tail_q] = 1'b1;
                    ready_d[tail_q] = 1'b0;
                    type_d[tail_q]  = Dispatch_type;
                    rd_d[tail_q]    = Dispatch_rd;
                    tail_d          = tail_q + ROB_W'(1);
                end
                if (do_cdb) begin
                    ready_d[CDB_pos]   = 1'b1;
                    value_d[CDB_pos]   = CDB_value;
                    mispred_d[CDB_pos] = CDB_mispred;
                    target_d[CDB_pos]  = CDB_target;
                end
                case (state_q)
                    IDLE: if (valid_q[head_q] && ready_q[head_q]) begin
                        if (type_q[head_q] == TYPE_STORE) begin
                            store_s_d = 1'b1;
                            state_d   = ST_WAIT;
                        end else begin
                            retire       = 1'b1;
                            write_s_d    = (rd_q[head_q] != '0);
                            commit_rd_d  = rd_q[head_q];
                            commit_pos_d = head_q;
                            commit_val_d = value_q[head_q];
                            if (type_q[head_q] == TYPE_BRANCH && mispred_q[head_q]) begin
                                clr_d    = 1'b1;
                                clr_pc_d = target_q[head_q];
                            end
                        end
                    end
                    ST_WAIT: if (LSB_store_done) begin
                        retire  = 1'b1;
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
                if (retire) begin
                    valid_d[head_q] = 1'b0;
                    ready_d[head_q] = 1'b0;
                    head_d          = head_q + ROB_W'(1);
                end
                count_d = count_q + (ROB_W+1)'(do_alloc) - (ROB_W+1)'(retire);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE; head_q <= '0; tail_q <= '0; count_q <= '0;
            valid_q <= '0; ready_q <= '0; mispred_q <= '0;
            type_q <= '{default: '0}; rd_q <= '{default: '0};
            value_q <= '{default: '0}; target_q <= '{default: '0};
            write_s_q <= 1'b0; store_s_q <= 1'b0; clr_q <= 1'b0;
            commit_rd_q <= '0; commit_pos_q <= '0; commit_val_q <= '0; clr_pc_q <= '0;
        end else begin
            state_q <= state_d; head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
            valid_q <= valid_d; ready_q <= ready_d; mispred_q <= mispred_d;
            type_q <= type_d; rd_q <= rd_d; value_q <= value_d; target_q <= target_d;
            write_s_q <= write_s_d; store_s_q <= store_s_d; clr_q <= clr_d;
            commit_rd_q <= commit_rd_d; commit_pos_q <= commit_pos_d;
            commit_val_q <= commit_val_d; clr_pc_q <= clr_pc_d;
        end
    end

`ifdef ROB_FWD_EN
    always_comb begin
        ROB_q1_ready = valid_q[Dispatch_q1_pos] && ready_q[Dispatch_q1_pos];
        ROB_q1_value = value_q[Dispatch_q1_pos];
        ROB_q2_ready = valid_q[Dispatch_q2_pos] && ready_q[Dispatch_q2_pos];
        ROB_q2_value = value_q[Dispatch_q2_pos];
        if (CDB_S && valid_q[CDB_pos] && CDB_pos == Dispatch_q1_pos) begin
            ROB_q1_ready = 1'b1;
            ROB_q1_value = CDB_value;
        end
        if (CDB_S && valid_q[CDB_pos] && CDB_pos == Dispatch_q2_pos) begin
            ROB_q2_ready = 1'b1;
            ROB_q2_value = CDB_value;
        end
    end
`endif
endmodule
